// File: rtl/fpdiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fpdiv_seq
//  Description : Moore sequencer for a single-multiplier Goldschmidt floating
//                point divider. One multiply per cycle, in this order:
//                N*IA, D*IA, ITER rounds of {A*C, B*C}, then the Q*D
//                remainder product. Drives the register enables and the
//                multiplier operand selects of the neighbouring datapath.
//                Optional build macro FPDIV_SEQ_ABORT_EN adds an abort input
//                that returns a busy sequencer to IDLE without pulsing done.
//  Revision    : 1.0  initial release
// ============================================================================
module fpdiv_seq #(
    parameter int ITER  = 3,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef FPDIV_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic             en_a,
    output logic             en_b,
    output logic             en_rem,
    output logic [1:0]       sel_mux3,
    output logic [1:0]       sel_mux4,
    output logic [CNT_W-1:0] iter
);

    // Reject illegal round counts and counters too narrow to hold them.
    generate
        if ((ITER < 1) || (ITER > 7)) begin : g_bad_iter
            $error("fpdiv_seq: ITER must be in 1..7");
        end
        if ((1 << CNT_W) <= ITER) begin : g_bad_cnt_w
            $error("fpdiv_seq: CNT_W too narrow for ITER");
        end
    endgenerate

    localparam logic [2:0] C_ST_IDLE   = 3'd0;
    localparam logic [2:0] C_ST_SEED_N = 3'd1;
    localparam logic [2:0] C_ST_SEED_D = 3'd2;
    localparam logic [2:0] C_ST_ITER_A = 3'd3;
    localparam logic [2:0] C_ST_ITER_B = 3'd4;
    localparam logic [2:0] C_ST_REM    = 3'd5;
    localparam logic [2:0] C_ST_DONE   = 3'd6;

    localparam logic [CNT_W-1:0] C_ITER_LAST = CNT_W'(ITER - 1);

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [CNT_W-1:0] iter_q;
    logic [CNT_W-1:0] iter_d;
    logic             w_busy;

    // Busy covers every state that issues a multiply.
    always_comb begin
        w_busy = (state_q != C_ST_IDLE) && (state_q != C_ST_DONE);
    end

    // Next-state and round-counter logic; start is only looked at in IDLE/DONE.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        case (state_q)
            C_ST_IDLE: begin
                if (start) begin
                    state_d = C_ST_SEED_N;
                    iter_d  = '0;
                end
            end
            C_ST_SEED_N: begin
                state_d = C_ST_SEED_D;
            end
            C_ST_SEED_D: begin
                state_d = C_ST_ITER_A;
                iter_d  = '0;
            end
            C_ST_ITER_A: begin
                state_d = C_ST_ITER_B;
            end
            C_ST_ITER_B: begin
                if (iter_q == C_ITER_LAST) begin
                    state_d = C_ST_REM;
                end else begin
                    state_d = C_ST_ITER_A;
                    iter_d  = iter_q + 1'b1;
                end
            end
            C_ST_REM: begin
                state_d = C_ST_DONE;
                iter_d  = '0;
            end
            C_ST_DONE: begin
                iter_d  = '0;
                state_d = start ? C_ST_SEED_N : C_ST_IDLE;
            end
            default: begin
                state_d = C_ST_IDLE;
                iter_d  = '0;
            end
        endcase
`ifdef FPDIV_SEQ_ABORT_EN
        // Abort wins over any in-flight transition but never disturbs IDLE/DONE.
        if (abort && w_busy) begin
            state_d = C_ST_IDLE;
            iter_d  = '0;
        end
`endif
    end

    // State and round-counter registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= C_ST_IDLE;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    // Moore output decode: enables and operand selects depend on state only.
    always_comb begin
        busy     = w_busy;
        done     = 1'b0;
        en_a     = 1'b0;
        en_b     = 1'b0;
        en_rem   = 1'b0;
        sel_mux3 = 2'd0;
        sel_mux4 = 2'd0;
        iter     = '0;
        case (state_q)
            C_ST_SEED_N: begin
                en_a = 1'b1;
            end
            C_ST_SEED_D: begin
                en_b     = 1'b1;
                sel_mux4 = 2'd1;
            end
            C_ST_ITER_A: begin
                en_a     = 1'b1;
                sel_mux3 = 2'd1;
                sel_mux4 = 2'd2;
                iter     = iter_q;
            end
            C_ST_ITER_B: begin
                en_b     = 1'b1;
                sel_mux3 = 2'd1;
                sel_mux4 = 2'd3;
                iter     = iter_q;
            end
            C_ST_REM: begin
                en_rem   = 1'b1;
                sel_mux3 = 2'd2;
                sel_mux4 = 2'd2;
            end
            C_ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                done = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_fpdiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpdiv_seq
//  Description : Scoreboard bench for fpdiv_seq. Two instances (ITER=3 and
//                ITER=1) share stimulus; a schedule model predicts the output
//                vector of every cycle, a monitor compares on the falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fpdiv_seq;

`ifdef FPDIV_SEQ_ABORT_EN
    localparam bit C_ABORT_EN = 1'b1;
`else
    localparam bit C_ABORT_EN = 1'b0;
`endif

    typedef logic [11:0] exp_t;  // {busy,done,en_a,en_b,en_rem,sel3,sel4,iter}

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;

    logic       busy3, done3, en_a3, en_b3, en_rem3;
    logic [1:0] s3_3, s4_3;
    logic [2:0] iter3;
    logic       busy1, done1, en_a1, en_b1, en_rem1;
    logic [1:0] s3_1, s4_1;
    logic [2:0] iter1;

    fpdiv_seq #(.ITER(3), .CNT_W(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start),
`ifdef FPDIV_SEQ_ABORT_EN
        .abort(abort),
`endif
        .busy(busy3), .done(done3), .en_a(en_a3), .en_b(en_b3), .en_rem(en_rem3),
        .sel_mux3(s3_3), .sel_mux4(s4_3), .iter(iter3)
    );

    fpdiv_seq #(.ITER(1), .CNT_W(3)) u_dut1 (
        .clk(clk), .reset(reset), .start(start),
`ifdef FPDIV_SEQ_ABORT_EN
        .abort(abort),
`endif
        .busy(busy1), .done(done1), .en_a(en_a1), .en_b(en_b1), .en_rem(en_rem1),
        .sel_mux3(s3_1), .sel_mux4(s4_1), .iter(iter1)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t q3[$];
    exp_t q1[$];
    int   pos3 = 0;
    int   pos1 = 0;
    int   exp_done3 = 0, exp_done1 = 0;
    int   got_done3 = 0, got_done1 = 0;

    // Expected outputs at schedule position p of a divide with it rounds.
    // 0 = idle, 1 = N*IA, 2 = D*IA, then A/B pairs, then remainder, then done.
    function automatic exp_t rec_at(input int p, input int it);
        logic b, d, a, bb, r;
        logic [1:0] s3, s4;
        logic [2:0] ix;
        b = 0; d = 0; a = 0; bb = 0; r = 0; s3 = 0; s4 = 0; ix = 0;
        if (p >= 1 && p <= 2*it + 3) b = 1'b1;
        if (p == 1) begin
            a = 1'b1;
        end else if (p == 2) begin
            bb = 1'b1; s4 = 2'd1;
        end else if (p >= 3 && p <= 2*it + 2) begin
            ix = 3'((p - 3) / 2);
            s3 = 2'd1;
            if (((p - 3) % 2) == 0) begin a = 1'b1; s4 = 2'd2; end
            else begin bb = 1'b1; s4 = 2'd3; end
        end else if (p == 2*it + 3) begin
            r = 1'b1; s3 = 2'd2; s4 = 2'd2;
        end else if (p == 2*it + 4) begin
            d = 1'b1;
        end
        return {b, d, a, bb, r, s3, s4, ix};
    endfunction

    // Schedule advance at a clock edge, given start/abort seen at that edge.
    function automatic int next_pos(input int p, input int it, input bit st, input bit ab);
        if (ab && C_ABORT_EN && p >= 1 && p <= 2*it + 3) return 0;
        if (p == 0 || p == 2*it + 4) return st ? 1 : 0;
        return p + 1;
    endfunction

    // One clock cycle of stimulus: s = start, rl = reset level, ab = abort.
    task automatic cycle(input bit s, input bit rl, input bit ab);
        bit   rst_edge;
        exp_t e3, e1;
        @(posedge clk);
        #1;
        cyc++;
        rst_edge = (reset == 1'b0);
        if (rst_edge) begin
            pos3 = 0; pos1 = 0;
        end else begin
            pos3 = next_pos(pos3, 3, start, abort);
            pos1 = next_pos(pos1, 1, start, abort);
        end
        reset = rl;
        if (!rl) begin
            pos3 = 0; pos1 = 0;
        end
        e3 = rec_at(pos3, 3);
        e1 = rec_at(pos1, 1);
        if (e3[10]) exp_done3++;
        if (e1[10]) exp_done1++;
        q3.push_back(e3);
        q1.push_back(e1);
        start = s;
        abort = ab;
    endtask

    // Monitor: compare the DUT output vector against the scoreboard each cycle.
    initial begin
        exp_t e, a;
        forever begin
            @(negedge clk);
            if (q3.size() > 0) begin
                e = q3.pop_front();
                a = {busy3, done3, en_a3, en_b3, en_rem3, s3_3, s4_3, iter3};
                if (done3) got_done3++;
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL iter3_outputs cycle %0d: got %h expected %h", cyc, a, e);
                end
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                a = {busy1, done1, en_a1, en_b1, en_rem1, s3_1, s4_1, iter1};
                if (done1) got_done1++;
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL iter1_outputs cycle %0d: got %h expected %h", cyc, a, e);
                end
            end
        end
    end

    // Stimulus: directed scenarios, then a randomized stream.
    initial begin
        // reset held, outputs must be idle
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 1'b0);
        // single start pulse
        cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 13; i++) cycle(1'b0, 1'b1, 1'b0);
        // start held high for 25 cycles: back-to-back runs
        for (int i = 0; i < 25; i++) cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b0);
        // start pulses while busy are ignored
        for (int i = 0; i < 14; i++) cycle((i == 0) || (i == 3) || (i == 7), 1'b1, 1'b0);
        // reset during ITER_A, then a clean run
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b0);
        // abort on cycle 4 of a run (only meaningful with the abort build)
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, C_ABORT_EN);
        cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b0);
        // randomized stream
        for (int i = 0; i < 2000; i++) begin
            bit s, rl, ab;
            s  = ($urandom_range(99) < 30);
            rl = !($urandom_range(199) == 0);
            ab = C_ABORT_EN && ($urandom_range(99) < 3);
            cycle(s, rl, ab);
        end
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        n_checks++;
        if (q3.size() + q1.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q3.size() + q1.size());
        end
        n_checks++;
        if (got_done3 != exp_done3) begin
            n_fail++;
            $display("FAIL done_count_iter3: got %0d expected %0d", got_done3, exp_done3);
        end
        n_checks++;
        if (got_done1 != exp_done1) begin
            n_fail++;
            $display("FAIL done_count_iter1: got %0d expected %0d", got_done1, exp_done1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
